// File: rtl/rd_bus_arbiter.sv
// rtl/rd_bus_arbiter.sv - two-port (I/D) round-robin read-bus arbiter with one-entry request slots
module rd_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int BLK_W  = 128
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  output logic              i_rrdy,
  input  logic [3:0]        i_ren,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic              i_rvalid,
  output logic [BLK_W-1:0]  i_rdata,
  output logic              d_rrdy,
  input  logic [3:0]        d_ren,
  input  logic [ADDR_W-1:0] d_raddr,
  output logic              d_rvalid,
  output logic [BLK_W-1:0]  d_rdata,
  input  logic              dev_rrdy,
  output logic [3:0]        dev_ren,
  output logic [ADDR_W-1:0] dev_raddr,
  input  logic              dev_rvalid,
  input  logic [BLK_W-1:0]  dev_rdata,
  output logic              err_spurious
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // side encoding shared by owner and last_grant
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  state_t              state_q, state_d;
  logic                pend_i_q, pend_i_d;
  logic                pend_d_q, pend_d_d;
  logic [3:0]          slot_i_ren_q, slot_i_ren_d;
  logic [3:0]          slot_d_ren_q, slot_d_ren_d;
  logic [ADDR_W-1:0]   slot_i_addr_q, slot_i_addr_d;
  logic [ADDR_W-1:0]   slot_d_addr_q, slot_d_addr_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [3:0]          dev_ren_q, dev_ren_d;
  logic [ADDR_W-1:0]   dev_raddr_q, dev_raddr_d;
  logic                i_rvalid_q, i_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [BLK_W-1:0]    i_rdata_q, i_rdata_d;
  logic [BLK_W-1:0]    d_rdata_q, d_rdata_d;
  logic                err_q, err_d;
  logic                sel;

  // slot capture, grant selection, issue and response routing
  always_comb begin
    state_d       = state_q;
    pend_i_d      = pend_i_q;
    pend_d_d      = pend_d_q;
    slot_i_ren_d  = slot_i_ren_q;
    slot_d_ren_d  = slot_d_ren_q;
    slot_i_addr_d = slot_i_addr_q;
    slot_d_addr_d = slot_d_addr_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    dev_ren_d     = 4'h0;
    dev_raddr_d   = dev_raddr_q;
    i_rvalid_d    = 1'b0;
    d_rvalid_d    = 1'b0;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    err_d         = err_q;
    sel           = SIDE_I;

    // a request while the slot is full is ignored; capture and clear never coincide
    if (!pend_i_q && (|i_ren)) begin
      pend_i_d      = 1'b1;
      slot_i_ren_d  = i_ren;
      slot_i_addr_d = i_raddr;
    end
    if (!pend_d_q && (|d_ren)) begin
      pend_d_d      = 1'b1;
      slot_d_ren_d  = d_ren;
      slot_d_addr_d = d_raddr;
    end

    case (state_q)
      S_IDLE: begin
        if (dev_rvalid) begin
          err_d = 1'b1;
        end
        if (dev_rrdy && (pend_i_q || pend_d_q)) begin
          if (pend_i_q && pend_d_q) begin
            sel = ~last_grant_q;
          end else begin
            sel = pend_d_q ? SIDE_D : SIDE_I;
          end
          dev_ren_d    = (sel == SIDE_D) ? slot_d_ren_q  : slot_i_ren_q;
          dev_raddr_d  = (sel == SIDE_D) ? slot_d_addr_q : slot_i_addr_q;
          owner_d      = sel;
          last_grant_d = sel;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dev_rvalid) begin
          if (owner_q == SIDE_I) begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = dev_rdata;
            pend_i_d   = 1'b0;
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = dev_rdata;
            pend_d_d   = 1'b0;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers with synchronous reset; D is the last grant so I wins the first tie
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q       <= S_IDLE;
      pend_i_q      <= 1'b0;
      pend_d_q      <= 1'b0;
      slot_i_ren_q  <= 4'h0;
      slot_d_ren_q  <= 4'h0;
      slot_i_addr_q <= '0;
      slot_d_addr_q <= '0;
      owner_q       <= SIDE_I;
      last_grant_q  <= SIDE_D;
      dev_ren_q     <= 4'h0;
      dev_raddr_q   <= '0;
      i_rvalid_q    <= 1'b0;
      d_rvalid_q    <= 1'b0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_i_q      <= pend_i_d;
      pend_d_q      <= pend_d_d;
      slot_i_ren_q  <= slot_i_ren_d;
      slot_d_ren_q  <= slot_d_ren_d;
      slot_i_addr_q <= slot_i_addr_d;
      slot_d_addr_q <= slot_d_addr_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      dev_ren_q     <= dev_ren_d;
      dev_raddr_q   <= dev_raddr_d;
      i_rvalid_q    <= i_rvalid_d;
      d_rvalid_q    <= d_rvalid_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      err_q         <= err_d;
    end
  end

  assign i_rrdy       = !pend_i_q;
  assign d_rrdy       = !pend_d_q;
  assign i_rvalid     = i_rvalid_q;
  assign d_rvalid     = d_rvalid_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign dev_ren      = dev_ren_q;
  assign dev_raddr    = dev_raddr_q;
  assign err_spurious = err_q;

endmodule
